// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared defaults, pack/unpack helpers and saturation limits for cmul_pipe
package cmul_pkg;

  localparam int DEF_W     = 12;
  localparam int DEF_FRAC  = 10;
  localparam int DEF_CNT_W = 16;

  // Sign-extend the low w bits of x to 32 bits.
  function automatic logic signed [31:0] cmul_sext(input logic [31:0] x, input int w);
    logic signed [31:0] t;
    t = $signed(x << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Pack two w-bit components as {re, im}; re lands in the upper w bits.
  function automatic logic [63:0] cmul_pack(input logic [31:0] re, input logic [31:0] im, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((64'(re) & mask) << w) | (64'(im) & mask);
  endfunction

  // Real part of a packed {re, im} word, sign-extended.
  function automatic logic signed [31:0] cmul_unpack_re(input logic [63:0] v, input int w);
    return cmul_sext(32'(v >> w), w);
  endfunction

  // Imaginary part of a packed {re, im} word, sign-extended.
  function automatic logic signed [31:0] cmul_unpack_im(input logic [63:0] v, input int w);
    return cmul_sext(32'(v), w);
  endfunction

  // Largest value representable in a w-bit two's complement component.
  function automatic logic signed [31:0] cmul_sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement component.
  function automatic logic signed [31:0] cmul_sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - round-half-up by 2^FRAC then clamp to a W-bit signed range
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic signed [2*W:0]   sum,
  output logic signed [W-1:0]   res,
  output logic                  sat
);

  // One guard bit above the sum so the rounding bias can never overflow.
  localparam int SW = 2 * W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'(cmul_sat_max(W));
  localparam logic signed [SW-1:0] MINV = SW'(cmul_sat_min(W));

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] biased;
  logic signed [SW-1:0] shifted;

  assign ext = {sum[2*W], sum};

  generate
    if (FRAC > 0) begin : g_round
      assign biased = ext + (SW'(1) <<< (FRAC - 1));
    end else begin : g_no_round
      assign biased = ext;
    end
  endgenerate

  assign shifted = biased >>> FRAC;

  // Clamp the scaled value into the output range and flag when clamping occurred.
  always_comb begin
    res = shifted[W-1:0];
    sat = 1'b0;
    if (shifted > MAXV) begin
      res = MAXV[W-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      res = MINV[W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/cmul_pipe.sv
// rtl/cmul_pipe.sv - three-stage complex multiplier with global stall, round/saturate and sat counter
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*W-1:0]     c_in,
  input  logic [2*W-1:0]     t_in,
  input  logic               conj,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_data,
  output logic               out_sat,
  output logic [CNT_W-1:0]   sat_cnt,
  input  logic               sat_clr
);

  localparam int PW = 2 * W + 1;

  // The whole pipeline advances together; it only stops when a result is waiting downstream.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic signed [W-1:0] c_re, c_im, t_re, t_im;
  logic signed [W:0]   t_im_eff;

  assign c_re = W'(cmul_unpack_re(64'(c_in), W));
  assign c_im = W'(cmul_unpack_im(64'(c_in), W));
  assign t_re = W'(cmul_unpack_re(64'(t_in), W));
  assign t_im = W'(cmul_unpack_im(64'(t_in), W));

  // One extra bit keeps the negation of the most negative twiddle exact.
  assign t_im_eff = conj ? -((W+1)'(t_im)) : (W+1)'(t_im);

  logic              s1_valid;
  logic signed [W-1:0] s1_cr, s1_ci, s1_tr;
  logic signed [W:0]   s1_ti;

  // Stage 1: capture the operands with the conjugate already folded into the twiddle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cr    <= '0;
      s1_ci    <= '0;
      s1_tr    <= '0;
      s1_ti    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_cr    <= c_re;
      s1_ci    <= c_im;
      s1_tr    <= t_re;
      s1_ti    <= t_im_eff;
    end
  end

  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

  // Four partial products; every magnitude fits in 2W signed bits.
  always_comb begin
    m_rr = PW'(s1_cr) * PW'(s1_tr);
    m_ii = PW'(s1_ci) * PW'(s1_ti);
    m_ri = PW'(s1_cr) * PW'(s1_ti);
    m_ir = PW'(s1_ci) * PW'(s1_tr);
  end

  logic                  s2_valid;
  logic signed [2*W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  // Stage 2: register the products.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_rr    <= m_rr[2*W-1:0];
      s2_ii    <= m_ii[2*W-1:0];
      s2_ri    <= m_ri[2*W-1:0];
      s2_ir    <= m_ir[2*W-1:0];
    end
  end

  logic signed [PW-1:0] sum_re, sum_im;
  logic signed [W-1:0]  rs_re, rs_im;
  logic                 sat_re, sat_im;

  assign sum_re = PW'(s2_rr) - PW'(s2_ii);
  assign sum_im = PW'(s2_ri) + PW'(s2_ir);

  cmul_round_sat #(.W(W), .FRAC(FRAC)) u_rs_re (
    .sum (sum_re),
    .res (rs_re),
    .sat (sat_re)
  );

  cmul_round_sat #(.W(W), .FRAC(FRAC)) u_rs_im (
    .sum (sum_im),
    .res (rs_im),
    .sat (sat_im)
  );

  // Stage 3: output register; holds its contents while downstream is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_data  <= (2*W)'(cmul_pack(32'(rs_re), 32'(rs_im), W));
      out_sat   <= sat_re | sat_im;
    end
  end

  // Count delivered saturated samples; sticks at all-ones and a clear beats an increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
